// File: rtl/nand_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined NAND tree.
package nand_tree_pkg;

    localparam int unsigned STATS_W      = 16;
    localparam int unsigned N_IN_MIN     = 2;
    localparam int unsigned N_IN_MAX     = 64;
    localparam int unsigned CHANNELS_MIN = 1;
    localparam int unsigned CHANNELS_MAX = 8;

    // Number of pairwise reduction levels needed to fold n bits down to one.
    function automatic int unsigned levels(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((32'd1 << r) < n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Per-channel width after k levels; an odd leftover bit passes through.
    function automatic int unsigned level_width(input int unsigned n, input int unsigned k);
        int unsigned w;
        w = n;
        for (int unsigned i = 0; i < k; i++) begin
            w = (w + 1) / 2;
        end
        return w;
    endfunction

endpackage

// File: rtl/nand_tree_pipe_level.sv
// One registered pairwise-AND level of the NAND tree (module nand_tree_level).
// The final level sets INVERT so the NAND result itself is registered.
module nand_tree_level
    import nand_tree_pkg::*;
#(
    parameter int unsigned IN_W     = 6,
    parameter int unsigned CHANNELS = 1,
    parameter bit          INVERT   = 1'b0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        valid_i,
    output logic                                        valid_o,
    input  logic [CHANNELS*IN_W-1:0]                    data_i,
    output logic [CHANNELS*level_width(IN_W, 1)-1:0]    data_o
);

    localparam int unsigned OUT_W = level_width(IN_W, 1);

    logic [CHANNELS*OUT_W-1:0] red_c;
    logic [CHANNELS*OUT_W-1:0] data_d, data_q;
    logic                      valid_d, valid_q;

    // Adjacent-pair AND per channel; the unpaired top bit is forwarded.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar j = 0; j < OUT_W; j++) begin : g_pair
            if (2 * j + 1 < IN_W) begin : g_and
                assign red_c[c*OUT_W + j] = data_i[c*IN_W + 2*j] & data_i[c*IN_W + 2*j + 1];
            end else begin : g_pass
                assign red_c[c*OUT_W + j] = data_i[c*IN_W + 2*j];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = valid_i;
            data_d  = INVERT ? ~red_c : red_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/nand_tree_pipe.sv
// Multi-channel pipelined NAND reduction with a single valid/ready handshake.
// Define NAND_TREE_STATS_EN to add the saturating txn_count beat counter.
module nand_tree_pipe
    import nand_tree_pkg::*;
#(
    parameter int unsigned N_IN     = 6,
    parameter int unsigned CHANNELS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNELS*N_IN-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHANNELS-1:0]      out_data
`ifdef NAND_TREE_STATS_EN
    ,
    output logic [STATS_W-1:0]       txn_count
`endif
);

    localparam int unsigned L = levels(N_IN);

    if ((N_IN < N_IN_MIN) || (N_IN > N_IN_MAX)) begin : g_bad_n_in
        $error("nand_tree_pipe: N_IN=%0d outside 2..64", N_IN);
    end
    if ((CHANNELS < CHANNELS_MIN) || (CHANNELS > CHANNELS_MAX)) begin : g_bad_channels
        $error("nand_tree_pipe: CHANNELS=%0d outside 1..8", CHANNELS);
    end

    // Whole pipe advances together; it only stalls when the result is stuck.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int unsigned IW = level_width(N_IN, k);
        localparam int unsigned OW = level_width(N_IN, k + 1);

        logic [CHANNELS*IW-1:0] d_in;
        logic [CHANNELS*OW-1:0] d_out;
        logic                   v_in;
        logic                   v_out;

        if (k == 0) begin : g_first
            assign d_in = in_data;
            assign v_in = in_valid;
        end else begin : g_chain
            assign d_in = g_lvl[k-1].d_out;
            assign v_in = g_lvl[k-1].v_out;
        end

        nand_tree_level #(
            .IN_W     (IW),
            .CHANNELS (CHANNELS),
            .INVERT   (k == L - 1)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .valid_i (v_in),
            .valid_o (v_out),
            .data_i  (d_in),
            .data_o  (d_out)
        );
    end

    assign out_valid = g_lvl[L-1].v_out;
    assign out_data  = g_lvl[L-1].d_out;

`ifdef NAND_TREE_STATS_EN
    logic [STATS_W-1:0] txn_count_d, txn_count_q;

    // Accepted-beat counter, sticks at all-ones instead of wrapping.
    always_comb begin
        txn_count_d = txn_count_q;
        if (in_valid && en && (txn_count_q != {STATS_W{1'b1}})) begin
            txn_count_d = txn_count_q + STATS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
        end
    end

    assign txn_count = txn_count_q;
`endif

endmodule
